// File: rtl/tinker_pkg.sv
// Shared types and constants for the fetch-side prefetch queue.
package tinker_pkg;

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} fetch_state_t;

    localparam logic [63:0] TINKER_RESET_PC = 64'h2000;
    localparam int unsigned INSTR_BYTES     = 4;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] word;
    } fetch_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// DEPTH-entry circular buffer of fetched words; flush empties it by snapping wr_ptr to rd_ptr.
module prefetch_fifo
    import tinker_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  fetch_entry_t       wr_entry,
    output fetch_entry_t       head,
    output logic [CNT_W-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    // Flush wins over any concurrent push or pop.
    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && (count_q != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= rd_ptr_q;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && do_push) mem_q[wr_ptr_q] <= wr_entry;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/instr_prefetch_queue.sv
// Fetch stage: owns the fetch PC, issues one memory read at a time and queues words for decode.
module instr_prefetch_queue
    import tinker_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [63:0] RESET_PC = TINKER_RESET_PC,
    parameter int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             redirect_valid,
    input  logic [63:0]      redirect_pc,
    input  logic             fetch_stop,
    output logic             mem_req,
    output logic [63:0]      mem_addr,
    input  logic             mem_ack,
    input  logic [31:0]      mem_rdata,
    output logic             instr_valid,
    output logic [31:0]      instr_data,
    output logic [63:0]      instr_pc,
    input  logic             instr_ready,
    output logic [CNT_W-1:0] queue_count
);

    fetch_state_t     state_q;
    logic [63:0]      fetch_pc_q;
    logic             mem_req_q;
    logic [63:0]      mem_addr_q;
    logic             push;
    logic             pop;
    fetch_entry_t     wr_entry;
    fetch_entry_t     head;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_PC;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (redirect_valid) begin
                        fetch_pc_q <= redirect_pc;
                    end else if (!fetch_stop && (count < CNT_W'(DEPTH))) begin
                        state_q    <= REQ;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= fetch_pc_q;
                    end
                end
                REQ: begin
                    if (redirect_valid) begin
                        fetch_pc_q <= redirect_pc;
                        if (mem_ack) begin
                            state_q   <= IDLE;
                            mem_req_q <= 1'b0;
                        end else begin
                            // The old read is still owed an ack; keep it alive and drop its data.
                            state_q <= DISCARD;
                        end
                    end else if (mem_ack) begin
                        fetch_pc_q <= fetch_pc_q + 64'(INSTR_BYTES);
                        state_q    <= IDLE;
                        mem_req_q  <= 1'b0;
                    end
                end
                DISCARD: begin
                    if (redirect_valid) fetch_pc_q <= redirect_pc;
                    if (mem_ack) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    // A slot was reserved when IDLE saw count < DEPTH, so push never meets a full queue.
    assign push          = (state_q == REQ) && mem_ack && !redirect_valid;
    assign pop           = instr_valid && instr_ready && !redirect_valid;
    assign wr_entry.pc   = fetch_pc_q;
    assign wr_entry.word = mem_rdata;

    prefetch_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .flush    (redirect_valid),
        .wr_entry (wr_entry),
        .head     (head),
        .count    (count)
    );

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign instr_valid = (count != '0);
    assign instr_data  = head.word;
    assign instr_pc    = head.pc;
    assign queue_count = count;

endmodule
